// File: rtl/trie_stage_ctrl_if.sv
// ============================================================================
// trie_stage_ctrl_if : lookup bundle passed between trie levels
// Rev 1.0
// ============================================================================
`default_nettype none

interface trie_stage_ctrl_if #(
  parameter int IP_WIDTH = 32,
  parameter int BLK_W    = 4
);
  logic                valid;
  logic [IP_WIDTH-1:0] ip;
  logic [7:0]          nh;
  logic                nh_valid;
  logic [BLK_W-1:0]    blk;
  logic                done;

  modport master (output valid, ip, nh, nh_valid, blk, done);
  modport slave  (input  valid, ip, nh, nh_valid, blk, done);
endinterface

`default_nettype wire

// File: rtl/trie_stage_ctrl.sv
// ============================================================================
// trie_stage_ctrl : per-level lookup controller of the 4-bit trie pipeline
// Optional statistics counters enabled by `define STAGE_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module trie_stage_ctrl #(
  parameter int IP_WIDTH   = 32,
  parameter int STAGE_IDX  = 0,
  parameter int BLK_W      = 4,
  parameter int NEXT_BLK_W = 6,
  parameter int LAST_STAGE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  trie_stage_ctrl_if.slave        lkp_in,
  output logic [BLK_W+3:0]        ram_addr,
  input  logic [NEXT_BLK_W+8:0]   ram_dout,
  trie_stage_ctrl_if.master       lkp_out
`ifdef STAGE_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [31:0]             stat_lookups,
  output logic [31:0]             stat_hits
`endif
);

  localparam int DATA_WIDTH = 9 + NEXT_BLK_W;
  localparam int NIB_MSB    = IP_WIDTH - 1 - 4 * STAGE_IDX;

  // Address is driven every cycle; the RAM read of an idle slot is harmless.
  assign ram_addr = {lkp_in.blk, lkp_in.ip[NIB_MSB -: 4]};

  logic                  ram_exist;
  logic [7:0]            ram_nh;
  logic [NEXT_BLK_W-1:0] ram_child;

  assign ram_exist = ram_dout[DATA_WIDTH-1];
  assign ram_nh    = ram_dout[DATA_WIDTH-2 -: 8];
  assign ram_child = ram_dout[NEXT_BLK_W-1:0];

  logic                  s1_valid_q, s1_valid_d;
  logic [IP_WIDTH-1:0]   s1_ip_q, s1_ip_d;
  logic [7:0]            s1_nh_q, s1_nh_d;
  logic                  s1_nh_valid_q, s1_nh_valid_d;
  logic                  s1_done_q, s1_done_d;

  logic                  out_valid_q, out_valid_d;
  logic [IP_WIDTH-1:0]   out_ip_q, out_ip_d;
  logic [7:0]            out_nh_q, out_nh_d;
  logic                  out_nh_valid_q, out_nh_valid_d;
  logic                  out_done_q, out_done_d;
  logic [NEXT_BLK_W-1:0] out_blk_q, out_blk_d;

  always_comb begin
    s1_valid_d    = lkp_in.valid;
    s1_ip_d       = lkp_in.ip;
    s1_nh_d       = lkp_in.nh;
    s1_nh_valid_d = lkp_in.nh_valid;
    s1_done_d     = lkp_in.done;
  end

  always_comb begin
    out_valid_d    = s1_valid_q;
    out_ip_d       = out_ip_q;
    out_nh_d       = out_nh_q;
    out_nh_valid_d = out_nh_valid_q;
    out_done_d     = out_done_q;
    out_blk_d      = out_blk_q;
    if (s1_valid_q) begin
      out_ip_d       = s1_ip_q;
      out_nh_d       = s1_nh_q;
      out_nh_valid_d = s1_nh_valid_q;
      out_done_d     = 1'b1;
      out_blk_d      = '0;
      if (!s1_done_q) begin
        if (ram_exist) begin
          out_nh_d       = ram_nh;
          out_nh_valid_d = 1'b1;
        end
        // Child 0 is the null block; a leaf level never descends further.
        if ((ram_child != '0) && (LAST_STAGE == 0)) begin
          out_done_d = 1'b0;
          out_blk_d  = ram_child;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_ip_q        <= '0;
      s1_nh_q        <= '0;
      s1_nh_valid_q  <= 1'b0;
      s1_done_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_ip_q       <= '0;
      out_nh_q       <= '0;
      out_nh_valid_q <= 1'b0;
      out_done_q     <= 1'b0;
      out_blk_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_ip_q        <= s1_ip_d;
      s1_nh_q        <= s1_nh_d;
      s1_nh_valid_q  <= s1_nh_valid_d;
      s1_done_q      <= s1_done_d;
      out_valid_q    <= out_valid_d;
      out_ip_q       <= out_ip_d;
      out_nh_q       <= out_nh_d;
      out_nh_valid_q <= out_nh_valid_d;
      out_done_q     <= out_done_d;
      out_blk_q      <= out_blk_d;
    end
  end

  assign lkp_out.valid    = out_valid_q;
  assign lkp_out.ip       = out_ip_q;
  assign lkp_out.nh       = out_nh_q;
  assign lkp_out.nh_valid = out_nh_valid_q;
  assign lkp_out.done     = out_done_q;
  assign lkp_out.blk      = out_blk_q;

`ifdef STAGE_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic        stat_count;

  assign stat_count = s1_valid_q && !s1_done_q;

  // Clear takes priority; both counters stick at all-ones.
  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_hits_d    = stat_hits_q;
    if (stat_clr) begin
      stat_lookups_d = '0;
      stat_hits_d    = '0;
    end else if (stat_count) begin
      if (stat_lookups_q != 32'hFFFF_FFFF) stat_lookups_d = stat_lookups_q + 32'd1;
      if (ram_exist && (stat_hits_q != 32'hFFFF_FFFF)) stat_hits_d = stat_hits_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_trie_stage_ctrl.sv
// ============================================================================
// tb_trie_stage_ctrl : directed self-checking bench for trie_stage_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trie_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ram_addr;
  logic [14:0] ram_dout = '0;
  logic [14:0] mem [256];
  int          checks   = 0;
  int          failures = 0;
`ifdef STAGE_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_lookups, stat_hits;
`endif

  trie_stage_ctrl_if #(.IP_WIDTH(32), .BLK_W(4)) up_if ();
  trie_stage_ctrl_if #(.IP_WIDTH(32), .BLK_W(6)) dn_if ();

  trie_stage_ctrl #(
    .IP_WIDTH(32), .STAGE_IDX(0), .BLK_W(4), .NEXT_BLK_W(6), .LAST_STAGE(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lkp_in   (up_if),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .lkp_out  (dn_if)
`ifdef STAGE_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_lookups (stat_lookups),
    .stat_hits    (stat_hits)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stage_ram: one-cycle registered read
  always @(posedge clk) ram_dout <= mem[ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [31:0] ip, input logic [3:0] blk, input logic [7:0] nh,
                       input logic nhv, input logic done);
    up_if.valid    = 1'b1;
    up_if.ip       = ip;
    up_if.blk      = blk;
    up_if.nh       = nh;
    up_if.nh_valid = nhv;
    up_if.done     = done;
  endtask

  task automatic idle();
    up_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    up_if.ip = '0; up_if.blk = '0; up_if.nh = '0; up_if.nh_valid = 1'b0; up_if.done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dn_if.valid); end
    checks++; if (dn_if.nh !== 8'h00) begin failures++; $display("FAIL reset_nh got=%h exp=00", dn_if.nh); end
    checks++; if (dn_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dn_if.done); end
    checks++; if (dn_if.blk !== 6'd0) begin failures++; $display("FAIL reset_blk got=%0d exp=0", dn_if.blk); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit();
    drive(32'hC0A8_0001, 4'h3, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (ram_addr !== 8'h3C) begin failures++; $display("FAIL hit_addr got=%h exp=3c", ram_addr); end
    @(negedge clk);
    idle();
    checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL hit_latency got=%b exp=0", dn_if.valid); end
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b1) begin failures++; $display("FAIL hit_valid got=%b exp=1", dn_if.valid); end
    checks++; if (dn_if.nh !== 8'h2A) begin failures++; $display("FAIL hit_nh got=%h exp=2a", dn_if.nh); end
    checks++; if (dn_if.nh_valid !== 1'b1) begin failures++; $display("FAIL hit_nhv got=%b exp=1", dn_if.nh_valid); end
    checks++; if (dn_if.blk !== 6'd5) begin failures++; $display("FAIL hit_blk got=%0d exp=5", dn_if.blk); end
    checks++; if (dn_if.done !== 1'b0) begin failures++; $display("FAIL hit_done got=%b exp=0", dn_if.done); end
    checks++; if (dn_if.ip !== 32'hC0A8_0001) begin failures++; $display("FAIL hit_ip got=%h exp=c0a80001", dn_if.ip); end
    @(negedge clk);
  endtask

  task automatic test_miss_null();
    drive(32'h5000_0000, 4'h2, 8'h11, 1'b1, 1'b0);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b1) begin failures++; $display("FAIL miss_valid got=%b exp=1", dn_if.valid); end
    checks++; if (dn_if.nh !== 8'h11) begin failures++; $display("FAIL miss_nh got=%h exp=11", dn_if.nh); end
    checks++; if (dn_if.nh_valid !== 1'b1) begin failures++; $display("FAIL miss_nhv got=%b exp=1", dn_if.nh_valid); end
    checks++; if (dn_if.done !== 1'b1) begin failures++; $display("FAIL miss_done got=%b exp=1", dn_if.done); end
    checks++; if (dn_if.blk !== 6'd0) begin failures++; $display("FAIL miss_blk got=%0d exp=0", dn_if.blk); end
    @(negedge clk);
  endtask

  task automatic test_done_passthrough();
`ifdef STAGE_STATS_EN
    logic [31:0] lk_before;
    lk_before = stat_lookups;
`endif
    drive(32'hA000_0000, 4'h4, 8'h07, 1'b1, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b1) begin failures++; $display("FAIL done_valid got=%b exp=1", dn_if.valid); end
    checks++; if (dn_if.nh !== 8'h07) begin failures++; $display("FAIL done_nh got=%h exp=07", dn_if.nh); end
    checks++; if (dn_if.done !== 1'b1) begin failures++; $display("FAIL done_done got=%b exp=1", dn_if.done); end
    checks++; if (dn_if.blk !== 6'd0) begin failures++; $display("FAIL done_blk got=%0d exp=0", dn_if.blk); end
    @(negedge clk);
`ifdef STAGE_STATS_EN
    checks++; if (stat_lookups !== lk_before) begin failures++; $display("FAIL done_stats got=%0d exp=%0d", stat_lookups, lk_before); end
`endif
  endtask

  task automatic test_back_to_back();
    drive(32'h1000_0001, 4'h1, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(32'h2000_0002, 4'h2, 8'h00, 1'b0, 1'b0); @(negedge clk);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.blk, dn_if.done} !== {1'b1, 8'hA1, 6'd11, 1'b0}) begin failures++;
      $display("FAIL b2b_first got=%b/%h/%0d/%b exp=1/a1/11/0", dn_if.valid, dn_if.nh, dn_if.blk, dn_if.done); end
    drive(32'h3000_0003, 4'h3, 8'h55, 1'b1, 1'b0); @(negedge clk);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.blk, dn_if.ip} !== {1'b1, 8'hA2, 6'd12, 32'h2000_0002}) begin failures++;
      $display("FAIL b2b_second got=%b/%h/%0d/%h exp=1/a2/12/20000002", dn_if.valid, dn_if.nh, dn_if.blk, dn_if.ip); end
    idle(); @(negedge clk);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done} !== {1'b1, 8'h55, 1'b1, 6'd13, 1'b0}) begin failures++;
      $display("FAIL b2b_third got=%b/%h/%b/%0d/%b exp=1/55/1/13/0", dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done); end
    @(negedge clk);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.blk, dn_if.ip} !== {1'b0, 8'h55, 6'd13, 32'h3000_0003}) begin failures++;
      $display("FAIL b2b_hold got=%b/%h/%0d/%h exp=0/55/13/30000003", dn_if.valid, dn_if.nh, dn_if.blk, dn_if.ip); end
    // Lookup, idle, lookup: exist with null child, then miss with real child
    drive(32'h4000_0000, 4'h4, 8'h00, 1'b0, 1'b0); @(negedge clk);
    idle(); @(negedge clk);
    drive(32'h5000_0000, 4'h5, 8'h33, 1'b0, 1'b0);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done} !== {1'b1, 8'hA4, 1'b1, 6'd0, 1'b1}) begin failures++;
      $display("FAIL gap_first got=%b/%h/%b/%0d/%b exp=1/a4/1/0/1", dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done); end
    @(negedge clk); idle();
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.done} !== {1'b0, 8'hA4, 1'b1}) begin failures++;
      $display("FAIL gap_hold got=%b/%h/%b exp=0/a4/1", dn_if.valid, dn_if.nh, dn_if.done); end
    @(negedge clk);
    checks++; if ({dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done} !== {1'b1, 8'h33, 1'b0, 6'd7, 1'b0}) begin failures++;
      $display("FAIL gap_second got=%b/%h/%b/%0d/%b exp=1/33/0/7/0", dn_if.valid, dn_if.nh, dn_if.nh_valid, dn_if.blk, dn_if.done); end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    drive(32'hC000_0000, 4'h3, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(32'h1000_0000, 4'h1, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(32'h2000_0000, 4'h2, 8'h00, 1'b0, 1'b0);
    checks++; if (dn_if.valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", dn_if.valid); end
    #2 rst = 1'b1;
    #1;
    idle();
    checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", dn_if.valid); end
    checks++; if (dn_if.nh !== 8'h00) begin failures++; $display("FAIL rstmid_nh got=%h exp=00", dn_if.nh); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_drop[%0d] got=%b exp=0", i, dn_if.valid); end
    end
  endtask

`ifdef STAGE_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
    drive(32'hC000_0000, 4'h3, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(32'h1000_0000, 4'h1, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(32'h5000_0000, 4'h2, 8'h00, 1'b0, 1'b0); @(negedge clk);
    idle(); repeat (3) @(negedge clk);
    checks++; if (stat_lookups !== 32'd3) begin failures++; $display("FAIL stats_lookups got=%0d exp=3", stat_lookups); end
    checks++; if (stat_hits !== 32'd2) begin failures++; $display("FAIL stats_hits got=%0d exp=2", stat_hits); end
    stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
    checks++; if ({stat_lookups, stat_hits} !== 64'd0) begin failures++; $display("FAIL stats_clr got=%0d/%0d exp=0/0", stat_lookups, stat_hits); end
    force dut.stat_lookups_q = 32'hFFFF_FFFF;
    force dut.stat_hits_q    = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stat_lookups_q;
    release dut.stat_hits_q;
    drive(32'hC000_0000, 4'h3, 8'h00, 1'b0, 1'b0); @(negedge clk);
    idle(); repeat (3) @(negedge clk);
    checks++; if (stat_lookups !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stats_sat_lookups got=%h exp=ffffffff", stat_lookups); end
    checks++; if (stat_hits !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stats_sat_hits got=%h exp=ffffffff", stat_hits); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h3C] = {1'b1, 8'h2A, 6'd5};
    mem[8'h25] = {1'b0, 8'hFF, 6'd0};
    mem[8'h4A] = {1'b1, 8'h99, 6'd9};
    mem[8'h11] = {1'b1, 8'hA1, 6'd11};
    mem[8'h22] = {1'b1, 8'hA2, 6'd12};
    mem[8'h33] = {1'b0, 8'h00, 6'd13};
    mem[8'h44] = {1'b1, 8'hA4, 6'd0};
    mem[8'h55] = {1'b0, 8'h00, 6'd7};

    test_reset();
    test_hit();
    test_miss_null();
    test_done_passthrough();
    test_back_to_back();
    test_reset_midstream();
`ifdef STAGE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
